// File: rtl/ra_builder_if.sv
// VRAM write handshake shared by the TA-side writers.
// A word is accepted on a rising clock edge where ra_vram_wr=1 and vram_wait=0.
//   master: drives ra_vram_wr / ra_vram_addr / ra_vram_dout, samples vram_wait
//   slave : samples the write request, drives vram_wait
interface ra_builder_if #(
  parameter int ADDR_W = 24
);
  logic              ra_vram_wr;
  logic [ADDR_W-1:0] ra_vram_addr;
  logic [31:0]       ra_vram_dout;
  logic              vram_wait;

  modport master (
    output ra_vram_wr,
    output ra_vram_addr,
    output ra_vram_dout,
    input  vram_wait
  );

  modport slave (
    input  ra_vram_wr,
    input  ra_vram_addr,
    input  ra_vram_dout,
    output vram_wait
  );
endinterface

// File: rtl/ra_builder.sv
// Region Array writer.
// Walks the tile grid (x inner, y outer) and writes one RA entry per tile to
// VRAM starting at REGION_BASE. An entry is a control word followed by the
// Object List pointers for opaque, op_mod, trans, tr_mod and (format v2 only)
// puncht. Each OL block sits back to back in the OL area starting at OL_BASE;
// a block holds one fixed-size list per tile.
// Ports:
//   clock, reset_n   system clock, asynchronous active-low reset
//   start            1-cycle build request, only honoured when idle
//   REGION_BASE      RA byte base (word aligned internally)
//   OL_BASE          OL area byte base (word aligned internally)
//   TA_ALLOC_CTRL    per-type OPB size codes, 0 = list not present
//   FPU_PARAM_CFG    bit 21 selects the 6-word entry format
//   tiles_x_m1/_y_m1 grid size minus one
//   zclear           entries request a Z clear
//   vram             VRAM write handshake (master side)
//   busy             build in progress
//   done             1-cycle pulse once the final word is accepted
module ra_builder #(
  parameter int          ADDR_W    = 24,
  parameter logic [31:0] EMPTY_PTR = 32'h8000_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  REGION_BASE,
  input  logic [31:0]  OL_BASE,
  input  logic [31:0]  TA_ALLOC_CTRL,
  input  logic [31:0]  FPU_PARAM_CFG,
  input  logic [5:0]   tiles_x_m1,
  input  logic [5:0]   tiles_y_m1,
  input  logic         zclear,
  ra_builder_if.master vram,
  output logic         busy,
  output logic         done
);

  localparam int NTYPES = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  setup_k;
  logic [2:0]  word_idx;
  logic [5:0]  tile_x;
  logic [5:0]  tile_y;

  logic [ADDR_W-1:0] region_base_l;
  logic [1:0]        opb_l [NTYPES];
  logic              fmt_v2_l;
  logic [5:0]        xm1_l;
  logic [5:0]        ym1_l;
  logic              zclear_l;
  // Holds base[k] after SETUP, then the current tile's list pointer.
  logic [ADDR_W-1:0] run_ptr [NTYPES];

  logic [12:0] n_tiles;
  logic        accept;
  logic [2:0]  final_word;
  logic        last_word;
  logic        row_end;
  logic        last_tile;
  logic [5:0]  next_x;
  logic [5:0]  next_y;

  // Configuration bits this block never looks at.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{REGION_BASE[31:ADDR_W], REGION_BASE[1:0],
                             OL_BASE[31:ADDR_W], OL_BASE[1:0],
                             TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                             TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                             TA_ALLOC_CTRL[3:2],
                             FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0]};

  // Size in bytes of one list: 0 when absent, else 32/64/128.
  function automatic logic [ADDR_W-1:0] list_size(input logic [1:0] opb);
    list_size = (opb == 2'd0) ? '0 : (ADDR_W'(16) << opb);
  endfunction

  // Size of a whole per-type block: n lists of list_size bytes, done as a shift.
  function automatic logic [ADDR_W-1:0] block_size(input logic [1:0]  opb,
                                                   input logic [12:0] n);
    block_size = (opb == 2'd0) ? '0 : (ADDR_W'(n) << ({1'b0, opb} + 3'd4));
  endfunction

  // Control word: [31] last tile, [30] no-Z-clear, [28] flush (kept 0), [13:8] y, [7:2] x.
  function automatic logic [31:0] ctrl_word(input logic       last,
                                            input logic       zc,
                                            input logic [5:0] x,
                                            input logic [5:0] y);
    ctrl_word = {last, ~zc, 16'h0000, y, x, 2'b00};
  endfunction

  function automatic logic [31:0] ptr_word(input logic [1:0]        opb,
                                           input logic [ADDR_W-1:0] ptr);
    ptr_word = (opb == 2'd0) ? EMPTY_PTR : 32'(ptr);
  endfunction

  always_comb begin
    n_tiles    = ({7'd0, xm1_l} + 13'd1) * ({7'd0, ym1_l} + 13'd1);
    accept     = vram.ra_vram_wr && !vram.vram_wait;
    final_word = fmt_v2_l ? 3'd5 : 3'd4;
    last_word  = (word_idx == final_word);
    row_end    = (tile_x == xm1_l);
    last_tile  = row_end && (tile_y == ym1_l);
    next_x     = row_end ? 6'd0 : tile_x + 6'd1;
    next_y     = row_end ? tile_y + 6'd1 : tile_y;
  end

  // Sequencer and registered VRAM/status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      setup_k           <= '0;
      word_idx          <= '0;
      tile_x            <= '0;
      tile_y            <= '0;
      vram.ra_vram_wr   <= 1'b0;
      vram.ra_vram_addr <= '0;
      vram.ra_vram_dout <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            setup_k <= '0;
            state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          setup_k <= setup_k + 3'd1;
          if (setup_k == 3'd4) begin
            state             <= S_WRITE;
            tile_x            <= '0;
            tile_y            <= '0;
            word_idx          <= '0;
            vram.ra_vram_wr   <= 1'b1;
            vram.ra_vram_addr <= region_base_l;
            vram.ra_vram_dout <= ctrl_word((xm1_l == 6'd0) && (ym1_l == 6'd0),
                                           zclear_l, 6'd0, 6'd0);
          end
        end

        S_WRITE: begin
          // Outputs only move on accept, so they hold while vram_wait is high.
          if (accept) begin
            vram.ra_vram_addr <= vram.ra_vram_addr + ADDR_W'(4);
            if (!last_word) begin
              // Word w+1 is the pointer for type w.
              word_idx          <= word_idx + 3'd1;
              vram.ra_vram_dout <= ptr_word(opb_l[word_idx], run_ptr[word_idx]);
            end else if (last_tile) begin
              state           <= S_DONE;
              vram.ra_vram_wr <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
            end else begin
              word_idx          <= '0;
              tile_x            <= next_x;
              tile_y            <= next_y;
              vram.ra_vram_dout <= ctrl_word((next_x == xm1_l) && (next_y == ym1_l),
                                             zclear_l, next_x, next_y);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Latched configuration and list pointers (datapath, no reset needed).
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) begin
      region_base_l <= {REGION_BASE[ADDR_W-1:2], 2'b00};
      run_ptr[0]    <= {OL_BASE[ADDR_W-1:2], 2'b00};
      for (int k = 0; k < NTYPES; k++) begin
        opb_l[k] <= TA_ALLOC_CTRL[4*k +: 2];
      end
      fmt_v2_l <= FPU_PARAM_CFG[21];
      xm1_l    <= tiles_x_m1;
      ym1_l    <= tiles_y_m1;
      zclear_l <= zclear;
    end else if (state == S_SETUP) begin
      // Cycle k places block k+1 right after block k; the fifth cycle is idle.
      if (setup_k != 3'd4) begin
        run_ptr[setup_k + 3'd1] <= run_ptr[setup_k] + block_size(opb_l[setup_k], n_tiles);
      end
    end else if (state == S_WRITE && accept && last_word) begin
      for (int k = 0; k < NTYPES; k++) begin
        run_ptr[k] <= run_ptr[k] + list_size(opb_l[k]);
      end
    end
  end

endmodule
